// File: rtl/fifo_uart_readout.sv
// Reads 16-bit hit words from the event FIFO and ships them to the host as 8N1 UART bytes, high byte first.
// Define HEADER_EN to prefix every word with the 0xA5 sync byte.
module fifo_uart_readout #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned VALID_TIMEOUT = 4
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        RD_EMPTY,
    input  logic        RD_VALID,
    input  logic [15:0] OTUBE,
    output logic        RD_EN,
    output logic        TX,
    output logic        BUSY,
    output logic [15:0] WORD_COUNT,
    output logic        RD_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND
    } state_t;

`ifdef HEADER_EN
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  TMO_LAST  = 4'(VALID_TIMEOUT - 1);
    localparam logic [3:0]  STOP_BIT  = 4'd9;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [1:0]  byte_q, byte_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        tx_q, tx_d;
    logic        rd_en_q, rd_en_d;
    logic        busy_q, busy_d;
    logic [15:0] word_count_q, word_count_d;
    logic        rd_err_q, rd_err_d;
    logic [7:0]  cur_byte;

    always_comb begin
        case (byte_q)
`ifdef HEADER_EN
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = word_q[15:8];
`else
            2'd0:    cur_byte = word_q[15:8];
`endif
            default: cur_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        word_d       = word_q;
        byte_d       = byte_q;
        bit_d        = bit_q;
        clk_cnt_d    = clk_cnt_q;
        tmo_d        = tmo_q;
        tx_d         = tx_q;
        rd_en_d      = 1'b0;
        busy_d       = busy_q;
        word_count_d = word_count_q;
        rd_err_d     = rd_err_q;

        case (state_q)
            S_IDLE: begin
                if (!RD_EMPTY) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (RD_VALID) begin
                    word_d    = OTUBE;
                    byte_d    = '0;
                    bit_d     = '0;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = S_SEND;
                end else if (tmo_q == TMO_LAST) begin
                    rd_err_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            S_SEND: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_q == STOP_BIT) begin
                        // The word-done bookkeeping is folded into the last stop-bit edge so BUSY drops with IDLE entry.
                        if (byte_q == LAST_BYTE) begin
                            tx_d         = 1'b1;
                            busy_d       = 1'b0;
                            word_count_d = word_count_q + 16'd1;
                            state_d      = S_IDLE;
                        end else begin
                            byte_d = byte_q + 2'd1;
                            bit_d  = '0;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the captured word is reset too, so a reset mid-byte leaves no stale data that could leak into TX.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            byte_q       <= '0;
            bit_q        <= '0;
            clk_cnt_q    <= '0;
            tmo_q        <= '0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            word_count_q <= '0;
            rd_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling the pre-edge values.
            state_q      <= state_d;
            word_q       <= word_d;
            byte_q       <= byte_d;
            bit_q        <= bit_d;
            clk_cnt_q    <= clk_cnt_d;
            tmo_q        <= tmo_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            word_count_q <= word_count_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign RD_EN      = rd_en_q;
    assign TX         = tx_q;
    assign BUSY       = busy_q;
    assign WORD_COUNT = word_count_q;
    assign RD_ERR     = rd_err_q;

endmodule

// File: tb/tb_fifo_uart_readout.sv
// Directed bench for fifo_uart_readout: FIFO responder, UART decoder and a byte scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_readout;

    localparam int CPB = 4;
    localparam int VT  = 4;
`ifdef HEADER_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int WORD_CYC = NB * 10 * CPB;
    localparam int D3_WAIT  = 2 + (NB - 1) * 10 * CPB + 4 * CPB + 1;

    logic        clk100   = 1'b0;
    logic        reset    = 1'b1;
    logic        RD_EMPTY = 1'b1;
    logic        RD_VALID = 1'b0;
    logic [15:0] OTUBE    = '0;
    logic        RD_EN;
    logic        TX;
    logic        BUSY;
    logic [15:0] WORD_COUNT;
    logic        RD_ERR;

    fifo_uart_readout #(
        .CLKS_PER_BIT (CPB),
        .VALID_TIMEOUT(VT)
    ) dut (
        .clk100    (clk100),
        .reset     (reset),
        .RD_EMPTY  (RD_EMPTY),
        .RD_VALID  (RD_VALID),
        .OTUBE     (OTUBE),
        .RD_EN     (RD_EN),
        .TX        (TX),
        .BUSY      (BUSY),
        .WORD_COUNT(WORD_COUNT),
        .RD_ERR    (RD_ERR)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_falls = 0;
    int rd_en_run  = 0;
    bit valid_en   = 1'b1;
    logic busy_prev = 1'b0;

    logic [7:0]  exp_q[$];
    logic [15:0] fifo_q[$];
    int rd_en_cyc[$];
    int byte_start[$];
    int byte_end[$];
    int busy_fall_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_falls(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && busy_falls < target; i++) @(negedge clk100);
        check(tag, busy_falls, target);
        @(negedge clk100);
    endtask

    task automatic wait_rd_en(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk100);
            if (RD_EN === 1'b1) break;
        end
        check(tag, RD_EN, 1);
    endtask

    task automatic clear_logs();
        rd_en_cyc.delete();
        byte_start.delete();
        byte_end.delete();
        busy_fall_cyc.delete();
    endtask

    initial forever #5 clk100 = ~clk100;

    initial forever begin
        @(posedge clk100);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // FIFO model: RD_VALID one cycle after RD_EN, junk on OTUBE otherwise.
    initial begin
        logic [15:0] pend_w;
        bit pend;
        pend = 1'b0;
        pend_w = '0;
        forever begin
            @(posedge clk100);
            #1;
            RD_VALID = 1'b0;
            OTUBE    = 16'($urandom);
            if (pend) begin
                RD_VALID = 1'b1;
                OTUBE    = pend_w;
`ifdef HEADER_EN
                exp_q.push_back(8'hA5);
`endif
                exp_q.push_back(pend_w[15:8]);
                exp_q.push_back(pend_w[7:0]);
                pend = 1'b0;
            end
            if (RD_EN === 1'b1 && valid_en && fifo_q.size() > 0) begin
                pend_w = fifo_q.pop_front();
                pend   = 1'b1;
            end
            RD_EMPTY = (fifo_q.size() == 0);
        end
    end

    initial forever begin
        @(negedge clk100);
        if (RD_EN === 1'b1) begin
            rd_en_cyc.push_back(cyc);
            rd_en_run++;
            if (rd_en_run > 1) check("rd_en_pulse_width", rd_en_run, 1);
        end else begin
            rd_en_run = 0;
        end
        if (busy_prev === 1'b1 && BUSY === 1'b0) begin
            busy_falls++;
            busy_fall_cyc.push_back(cyc);
        end
        busy_prev = BUSY;
    end

    // UART decoder: one sample per cycle, every sample of a bit must agree.
    initial begin
        int cnt;
        int badf;
        bit active;
        logic [7:0] data;
        cnt = 0;
        badf = 0;
        active = 1'b0;
        data = '0;
        forever begin
            @(negedge clk100);
            if (reset === 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (TX === 1'b0) begin
                    active = 1'b1;
                    cnt    = 1;
                    badf   = 0;
                    data   = '0;
                    byte_start.push_back(cyc);
                end
            end else begin
                int b;
                int ph;
                b  = cnt / CPB;
                ph = cnt % CPB;
                if (b == 0) begin
                    if (TX !== 1'b0) badf++;
                end else if (b <= 8) begin
                    if (ph == 0) data[b-1] = TX;
                    else if (TX !== data[b-1]) badf++;
                end else begin
                    if (TX !== 1'b1) badf++;
                end
                cnt++;
                if (cnt == 10 * CPB) begin
                    active = 1'b0;
                    byte_end.push_back(cyc);
                    check("byte_framing", badf, 0);
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_byte: observed=0x%0h expected=none", data);
                    end
                    if (exp_q.size() != 0) check("byte_value", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int tgt;
        int n_tx0;
        int n_busy;
        int exp_wc;
        exp_wc = 0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk100);
        check("rst_tx", TX, 1);
        check("rst_rd_en", RD_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_word_count", WORD_COUNT, 0);
        check("rst_rd_err", RD_ERR, 0);
        reset = 1'b0;

        // Empty FIFO: nothing happens for 100 cycles.
        clear_logs();
        n_tx0 = 0;
        n_busy = 0;
        repeat (100) begin
            @(negedge clk100);
            if (TX !== 1'b1) n_tx0++;
            if (BUSY !== 1'b0) n_busy++;
        end
        check("idle_tx_low", n_tx0, 0);
        check("idle_busy", n_busy, 0);
        check("idle_rd_en", rd_en_cyc.size(), 0);

        // One word 0x1008.
        clear_logs();
        fifo_q.push_back(16'h1008);
        tgt = busy_falls + 1;
        wait_busy_falls("w1_done", tgt, WORD_CYC + 50);
        exp_wc++;
        check("w1_rd_en_pulses", rd_en_cyc.size(), 1);
        check("w1_start_latency", byte_start[0] - rd_en_cyc[0], 2);
        check("w1_busy_len", busy_fall_cyc[0] - rd_en_cyc[0], WORD_CYC + 2);
        check("w1_byte_count", byte_end.size(), NB);
        check("w1_back_to_back", byte_start[1] - byte_end[0], 1);
        check("w1_end_to_idle", busy_fall_cyc[0] - byte_end[NB-1], 1);
        check("w1_word_count", WORD_COUNT, exp_wc);
        check("w1_sb_empty", exp_q.size(), 0);

        // Three words back to back.
        clear_logs();
        fifo_q.push_back(16'h0201);
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'h0000);
        tgt = busy_falls + 3;
        wait_busy_falls("w3_done", tgt, 3 * (WORD_CYC + 3) + 50);
        exp_wc += 3;
        check("w3_rd_en_pulses", rd_en_cyc.size(), 3);
        check("w3_gap_1", rd_en_cyc[1] - byte_end[NB-1], 2);
        check("w3_gap_2", rd_en_cyc[2] - byte_end[2*NB-1], 2);
        check("w3_period", rd_en_cyc[2] - rd_en_cyc[1], WORD_CYC + 3);
        check("w3_word_count", WORD_COUNT, exp_wc);
        check("w3_sb_empty", exp_q.size(), 0);

        // RD_VALID withheld: timeout, then a retry that succeeds.
        clear_logs();
        valid_en = 1'b0;
        fifo_q.push_back(16'h5A3C);
        wait_rd_en("to_rd_en", 20);
        n_tx0 = 0;
        repeat (3) begin
            @(negedge clk100);
            if (TX !== 1'b1) n_tx0++;
        end
        check("to_err_early", RD_ERR, 0);
        @(negedge clk100);
        if (TX !== 1'b1) n_tx0++;
        check("to_err_set", RD_ERR, 1);
        check("to_busy", BUSY, 0);
        check("to_word_count", WORD_COUNT, exp_wc);
        valid_en = 1'b1;
        @(negedge clk100);
        check("to_retry_rd_en", RD_EN, 1);
        check("to_tx_idle", n_tx0, 0);
        tgt = busy_falls + 1;
        wait_busy_falls("to_retry_done", tgt, WORD_CYC + 50);
        exp_wc++;
        check("to_retry_word_count", WORD_COUNT, exp_wc);
        check("to_err_sticky", RD_ERR, 1);
        check("to_sb_empty", exp_q.size(), 0);

        // Reset during D3 of the low byte.
        clear_logs();
        fifo_q.push_back(16'hC3E7);
        wait_rd_en("mr_rd_en", 20);
        repeat (D3_WAIT) @(negedge clk100);
        check("mr_pre_tx_d3", TX, 0);
        #2 reset = 1'b1;
        #1;
        exp_wc = 0;
        check("mr_tx", TX, 1);
        check("mr_busy", BUSY, 0);
        check("mr_word_count", WORD_COUNT, exp_wc);
        check("mr_rd_en", RD_EN, 0);
        check("mr_rd_err", RD_ERR, 0);
        @(negedge clk100);
        @(negedge clk100);
        exp_q.delete();
        fifo_q.push_back(16'h4B2D);
        @(negedge clk100);
        reset = 1'b0;
        tgt = busy_falls + 1;
        wait_busy_falls("mr_fresh_done", tgt, WORD_CYC + 50);
        exp_wc++;
        check("mr_fresh_word_count", WORD_COUNT, exp_wc);
        check("mr_sb_empty", exp_q.size(), 0);

        // WORD_COUNT wrap from 0xFFFF.
        @(negedge clk100);
        force dut.word_count_q = 16'hFFFF;
        #1 release dut.word_count_q;
        #1;
        exp_wc = 16'hFFFF;
        check("wrap_preload", WORD_COUNT, exp_wc);
        fifo_q.push_back(16'h8001);
        tgt = busy_falls + 1;
        wait_busy_falls("wrap_done", tgt, WORD_CYC + 50);
        exp_wc = (exp_wc + 1) & 16'hFFFF;
        check("wrap_word_count", WORD_COUNT, exp_wc);
        check("wrap_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
